ddr_cas_responder: RTL and testbench

- DRAM-side responder for the CAS command stream that the controller's burst/CAS sequencer issues.
- Decodes ACT/RD/RDA/WR/WRA per bank and checks tRCD, tCCD, read-to-write and write-to-read spacing.
- Schedules each data burst at RL or WL and drives the data-window strobes.
- Returns rw_done to the controller on the last beat of each burst. Sits between the command bus and the DQ model in the bench/device model.

---
 rtl/ddr_cas_responder_pkg.sv | 37 +++
 rtl/cas_burst_fifo.sv | 72 +++++++
 rtl/ddr_cas_responder.sv | 244 ++++++++++++++++++++++++
 tb/tb_ddr_cas_responder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ddr_cas_responder_pkg.sv
// Shared request codes, timing constants and queue entry type for the CAS responder.
// Used unchanged with or without CAS_AUTOPRE_EN.
package ddr_pkg;

    localparam int STAMP_W = 16;

    localparam logic [2:0] NOP_R = 3'd0;
    localparam logic [2:0] ACT_R = 3'd1;
    localparam logic [2:0] RD_R  = 3'd2;
    localparam logic [2:0] RDA_R = 3'd3;
    localparam logic [2:0] WR_R  = 3'd4;
    localparam logic [2:0] WRA_R = 3'd5;

    localparam logic [7:0] tRCD = 8'd4;
    localparam logic [7:0] tWTR = 8'd4;

    typedef enum logic [1:0] {
        B_IDLE,
        B_WAIT,
        B_XFER
    } burst_fsm_type;

    // start holds the cycle stamp of the first data beat.
    typedef struct packed {
        logic               is_wr;
        logic [STAMP_W-1:0] start;
    } cas_entry_t;

    function automatic logic is_cas_code(input logic [2:0] c);
        return (c == RD_R) || (c == RDA_R) || (c == WR_R) || (c == WRA_R);
    endfunction

    function automatic logic is_wr_code(input logic [2:0] c);
        return (c == WR_R) || (c == WRA_R);
    endfunction

endpackage

// File: rtl/cas_burst_fifo.sv
// Pending-burst queue: DEPTH-entry synchronous FIFO, push and pop may coincide,
// and a push into a full queue is accepted only when a pop frees a slot that cycle.
module cas_burst_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic         CK_t,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = bump(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = bump(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ddr_cas_responder.sv
// DRAM-side CAS responder: per-bank ACT tracking, CAS spacing checks, burst scheduling.
// Optional macro CAS_AUTOPRE_EN adds bank-open tracking and auto-precharge on RDA/WRA.
//
// state  | meaning
// B_IDLE | no pending burst
// B_WAIT | head burst queued, waiting for its start stamp
// B_XFER | data beats in progress (rd_win or wr_win high)
module ddr_cas_responder
    import ddr_pkg::*;
#(
    parameter int BANKS = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = STAMP_W
) (
    input  logic                     CK_t,
    input  logic                     reset,
    input  logic                     cmd_valid,
    input  logic [2:0]               cmd,
    input  logic [$clog2(BANKS)-1:0] bank,
    input  logic [4:0]               CL,
    input  logic [4:0]               AL,
    input  logic [4:0]               CWL,
    input  logic [4:0]               BL,
    input  logic [3:0]               tCCD,
    output logic                     rd_win,
    output logic                     wr_win,
    output logic                     rw_done,
    output logic                     trcd_viol,
    output logic                     tccd_viol,
    output logic                     rtw_viol,
    output logic                     wtr_viol,
    output logic                     q_ovf
);

    localparam int BW    = $clog2(BANKS);
    localparam int ENT_W = $bits(cas_entry_t);
`ifdef CAS_AUTOPRE_EN
    localparam int FW = ENT_W + 1 + BW;
`else
    localparam int FW = ENT_W;
`endif

    logic [CNT_W-1:0] now_q, now_d;
    logic [CNT_W-1:0] act_stamp_q [BANKS];
    logic [CNT_W-1:0] act_stamp_d [BANKS];
    logic [CNT_W-1:0] last_cas_q, last_cas_d;
    logic             last_wr_q, last_wr_d;
    logic             no_prev_q, no_prev_d;
    burst_fsm_type    state_q, state_d;
    logic [4:0]       beat_q, beat_d;
    logic             cur_wr_q, cur_wr_d;

    logic             is_act, is_cas, is_wr_cmd;
    logic [4:0]       half_bl;
    logic [CNT_W-1:0] gap_act, gap_cas, due_diff;
    logic signed [7:0] tccd_lim, rtw_lim, wtr_lim;
    logic [7:0]       wtr_sum;
    logic             trcd_v;

    cas_entry_t       new_ent, head;
    logic [FW-1:0]    fifo_din, fifo_dout;
    logic             fifo_full, fifo_empty, fifo_pop, head_due;

    // Gaps with the MSB set are treated as ancient history, i.e. satisfied.
    function automatic logic gap_short(input logic [CNT_W-1:0] gap,
                                       input logic signed [7:0] lim);
        logic [CNT_W-1:0] lim_ext;
        lim_ext      = '0;
        lim_ext[6:0] = lim[6:0];
        return !gap[CNT_W-1] && !lim[7] && (gap < lim_ext);
    endfunction

    assign is_act    = cmd_valid && (cmd == ACT_R);
    assign is_cas    = cmd_valid && is_cas_code(cmd);
    assign is_wr_cmd = is_wr_code(cmd);
    assign half_bl   = BL >> 1;

    assign gap_act  = now_q - act_stamp_q[bank];
    assign gap_cas  = now_q - last_cas_q;
    assign tccd_lim = $signed({4'b0000, tCCD});
    assign rtw_lim  = $signed({3'b000, CL}) - $signed({3'b000, AL}) - $signed({3'b000, CWL})
                    + $signed({3'b000, half_bl}) + 8'sd2;
    assign wtr_sum  = {3'b000, AL} + {3'b000, CWL} + {3'b000, half_bl} + tWTR;
    assign wtr_lim  = $signed(wtr_sum);

`ifdef CAS_AUTOPRE_EN
    logic [BANKS-1:0] open_q, open_d;
    logic             cur_ap_q, cur_ap_d;
    logic [BW-1:0]    cur_bank_q, cur_bank_d;
    logic             is_ap_cmd;

    assign is_ap_cmd = (cmd == RDA_R) || (cmd == WRA_R);
    assign trcd_v    = (is_cas && (gap_short(gap_act, $signed(tRCD)) || !open_q[bank]))
                    || (is_act && open_q[bank]);
    assign fifo_din  = {is_ap_cmd, bank, new_ent};
`else
    assign trcd_v    = is_cas && gap_short(gap_act, $signed(tRCD));
    assign fifo_din  = new_ent;
`endif

    assign trcd_viol = trcd_v;
    assign tccd_viol = is_cas && !no_prev_q && gap_short(gap_cas, tccd_lim);
    assign rtw_viol  = is_cas && !no_prev_q && !last_wr_q && is_wr_cmd
                    && gap_short(gap_cas, rtw_lim);
    assign wtr_viol  = is_cas && !no_prev_q && last_wr_q && !is_wr_cmd
                    && gap_short(gap_cas, wtr_lim);
    assign q_ovf     = is_cas && fifo_full && !fifo_pop;

    always_comb begin
        new_ent       = '0;
        new_ent.is_wr = is_wr_cmd;
        new_ent.start = now_q + CNT_W'(AL) + CNT_W'(is_wr_cmd ? CWL : CL);
    end

    cas_burst_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CK_t  (CK_t),
        .reset (reset),
        .push  (is_cas),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head     = cas_entry_t'(fifo_dout[ENT_W-1:0]);
    // Due when the head's start is next cycle or already behind us.
    assign due_diff = now_q + 1'b1 - head.start;
    assign head_due = !fifo_empty && !due_diff[CNT_W-1];

    assign rd_win  = (state_q == B_XFER) && !cur_wr_q;
    assign wr_win  = (state_q == B_XFER) && cur_wr_q;
    assign rw_done = (state_q == B_XFER) && (beat_q == 5'd0);

    always_comb begin
        now_d       = now_q + 1'b1;
        act_stamp_d = act_stamp_q;
        last_cas_d  = last_cas_q;
        last_wr_d   = last_wr_q;
        no_prev_d   = no_prev_q;
        if (is_act) begin
            act_stamp_d[bank] = now_q;
        end
        if (is_cas) begin
            last_cas_d = now_q;
            last_wr_d  = is_wr_cmd;
            no_prev_d  = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        cur_wr_d = cur_wr_q;
        fifo_pop = 1'b0;
        case (state_q)
            B_IDLE: begin
                if (!fifo_empty) begin
                    state_d = B_WAIT;
                end
            end
            B_WAIT: begin
                if (head_due) begin
                    state_d  = B_XFER;
                    fifo_pop = 1'b1;
                    beat_d   = half_bl - 5'd1;
                    cur_wr_d = head.is_wr;
                end
            end
            B_XFER: begin
                if (beat_q != 5'd0) begin
                    beat_d = beat_q - 5'd1;
                end else if (head_due) begin
                    fifo_pop = 1'b1;
                    beat_d   = half_bl - 5'd1;
                    cur_wr_d = head.is_wr;
                end else if (!fifo_empty) begin
                    state_d = B_WAIT;
                end else begin
                    state_d = B_IDLE;
                end
            end
            default: state_d = B_IDLE;
        endcase
    end

`ifdef CAS_AUTOPRE_EN
    always_comb begin
        open_d     = open_q;
        cur_ap_d   = cur_ap_q;
        cur_bank_d = cur_bank_q;
        if (rw_done && cur_ap_q) begin
            open_d[cur_bank_q] = 1'b0;
        end
        if (is_act) begin
            open_d[bank] = 1'b1;
        end
        if (fifo_pop) begin
            cur_ap_d   = fifo_dout[FW-1];
            cur_bank_d = fifo_dout[ENT_W +: BW];
        end
    end

    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            open_q     <= '0;
            cur_ap_q   <= 1'b0;
            cur_bank_q <= '0;
        end else begin
            open_q     <= open_d;
            cur_ap_q   <= cur_ap_d;
            cur_bank_q <= cur_bank_d;
        end
    end
`endif

    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            now_q      <= '0;
            for (int i = 0; i < BANKS; i++) begin
                act_stamp_q[i] <= '0;
            end
            last_cas_q <= '0;
            last_wr_q  <= 1'b0;
            no_prev_q  <= 1'b1;
            state_q    <= B_IDLE;
            beat_q     <= '0;
            cur_wr_q   <= 1'b0;
        end else begin
            now_q       <= now_d;
            act_stamp_q <= act_stamp_d;
            last_cas_q  <= last_cas_d;
            last_wr_q   <= last_wr_d;
            no_prev_q   <= no_prev_d;
            state_q     <= state_d;
            beat_q      <= beat_d;
            cur_wr_q    <= cur_wr_d;
        end
    end

endmodule

// File: tb/tb_ddr_cas_responder.sv
// Directed bench for ddr_cas_responder: table of short command scripts with
// hand-computed output timelines, plus hand-written overflow and reset-abort sequences.
module tb_ddr_cas_responder;
    import ddr_pkg::*;

    logic       CK_t = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd = NOP_R;
    logic [1:0] bank = 2'd0;
    logic [4:0] CL = 5'd11, AL = 5'd0, CWL = 5'd9, BL = 5'd8;
    logic [3:0] tCCD = 4'd4;
    logic rd_win, wr_win, rw_done, trcd_viol, tccd_viol, rtw_viol, wtr_viol, q_ovf;

    int errors = 0;
    int checks = 0;

    localparam int NC = 36;

    ddr_cas_responder dut (
        .CK_t      (CK_t),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .bank      (bank),
        .CL        (CL),
        .AL        (AL),
        .CWL       (CWL),
        .BL        (BL),
        .tCCD      (tCCD),
        .rd_win    (rd_win),
        .wr_win    (wr_win),
        .rw_done   (rw_done),
        .trcd_viol (trcd_viol),
        .tccd_viol (tccd_viol),
        .rtw_viol  (rtw_viol),
        .wtr_viol  (wtr_viol),
        .q_ovf     (q_ovf)
    );

    always #5 CK_t = ~CK_t;

    typedef struct {
        logic [2:0] c0; int t0;
        logic [2:0] c1; int t1;
        logic [2:0] c2; int t2;
        int trcd_at, tccd_at, rtw_at, wtr_at;
        int rd_lo, rd_hi, wr_lo, wr_hi;
        int done_a, done_b;
        string name;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [7:0] outs();
        return {rd_win, wr_win, rw_done, trcd_viol, tccd_viol, rtw_viol, wtr_viol, q_ovf};
    endfunction

    function automatic logic [7:0] exp_of(input vec_t v, input int c);
        logic [7:0] e;
        e    = '0;
        e[7] = (c >= v.rd_lo) && (c <= v.rd_hi);
        e[6] = (c >= v.wr_lo) && (c <= v.wr_hi);
        e[5] = (c == v.done_a) || (c == v.done_b);
        e[4] = (c == v.trcd_at);
        e[3] = (c == v.tccd_at);
        e[2] = (c == v.rtw_at);
        e[1] = (c == v.wtr_at);
        return e;
    endfunction

    task automatic check(input string name, input int c, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b exp=%b (rd wr done trcd tccd rtw wtr ovf)",
                     name, c, got, exp);
        end
    endtask

    // Leaves the bench at the start of cycle 0 (cycle stamp 0, reset released).
    task automatic do_reset();
        @(negedge CK_t);
        cmd_valid = 1'b0;
        cmd       = NOP_R;
        reset     = 1'b1;
        @(negedge CK_t);
        @(negedge CK_t);
        reset = 1'b0;
    endtask

    task automatic drive(input vec_t v, input int c);
        cmd_valid = 1'b0;
        cmd       = NOP_R;
        if (v.t0 == c) begin cmd_valid = 1'b1; cmd = v.c0; end
        if (v.t1 == c) begin cmd_valid = 1'b1; cmd = v.c1; end
        if (v.t2 == c) begin cmd_valid = 1'b1; cmd = v.c2; end
    endtask

    initial begin
        logic [7:0] e;

        vecs[0] = '{ACT_R, 0, RD_R, 4, NOP_R, -1, -1, -1, -1, -1, 15, 18, -1, -1, 18, -1, "act_rd"};
        vecs[1] = '{ACT_R, 0, RD_R, 4, RD_R, 8, -1, -1, -1, -1, 15, 22, -1, -1, 18, 22, "seamless"};
        vecs[2] = '{ACT_R, 0, RD_R, 4, RD_R, 6, -1, 6, -1, -1, 15, 22, -1, -1, 18, 22, "tccd"};
        vecs[3] = '{ACT_R, 0, WR_R, 2, NOP_R, -1, 2, -1, -1, -1, -1, -1, 11, 14, 14, -1, "trcd_wr"};
        vecs[4] = '{ACT_R, 0, RD_R, 4, WR_R, 9, -1, -1, 9, -1, 15, 18, 19, 22, 18, 22, "rtw"};
        vecs[5] = '{ACT_R, 0, WR_R, 4, RD_R, 10, -1, -1, -1, 10, 21, 24, 13, 16, 16, 24, "wtr"};
        vecs[6] = '{ACT_R, 0, RD_R, 4, WR_R, 12, -1, -1, -1, -1, 15, 18, 21, 24, 18, 24, "rtw_edge"};
        vecs[7] = '{WR_R, 1, NOP_R, -1, NOP_R, -1, 1, -1, -1, -1, -1, -1, 10, 13, 13, -1, "first_cas"};
        vecs[8] = '{ACT_R, 0, WR_R, 4, RD_R, 21, -1, -1, -1, -1, 32, 35, 13, 16, 16, 35, "wtr_edge"};

        #2;
        check("reset_state", 0, outs(), 8'h00);

        for (int s = 0; s < 9; s++) begin
            do_reset();
            for (int c = 0; c < NC; c++) begin
                drive(vecs[s], c);
                #2;
                check(vecs[s].name, c, outs(), exp_of(vecs[s], c));
                @(negedge CK_t);
            end
        end

        // Queue overflow with bursts held off by a long CL, then reset mid-burst.
        CL = 5'd31;
        do_reset();
        for (int c = 0; c <= 36; c++) begin
            cmd_valid = (c == 0) || ((c % 4 == 0) && (c >= 4) && (c <= 20));
            cmd       = (c == 0) ? ACT_R : RD_R;
            #2;
            e    = '0;
            e[7] = (c >= 35);
            e[0] = (c == 20);
            check("ovf_stall", c, outs(), e);
            if (c < 36) @(negedge CK_t);
        end
        cmd_valid = 1'b0;
        cmd       = NOP_R;
        #1;
        reset = 1'b1;
        #1;
        check("rst_abort", 36, outs(), 8'h00);
        for (int k = 37; k <= 41; k++) begin
            @(negedge CK_t);
            #2;
            check("rst_hold", k, outs(), 8'h00);
        end
        CL = 5'd11;
        do_reset();
        #2;
        check("post_reset", 0, outs(), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
